// File: rtl/car_motion_ctrl.sv
// Elevator car sequencer: times floor-to-floor travel and door dwell, owns the
// one-hot car position, and reports door/motion status to request processing.
module car_motion_ctrl #(
  parameter int MOVE_TICKS = 64,
  parameter int DOOR_TICKS = 96
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] ud_mode,
  input  logic [3:0] stop_req,
  input  logic       door_open_btn,
  input  logic       door_close_btn,
  output logic [3:0] position,
  output logic       door_open,
  output logic       moving,
  output logic [1:0] dir,
  output logic       arrive
);

  localparam int MAX_TICKS = (MOVE_TICKS > DOOR_TICKS) ? MOVE_TICKS : DOOR_TICKS;
  localparam int CW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

  localparam logic [CW-1:0] MOVE_LAST = CW'(MOVE_TICKS - 1);
  localparam logic [CW-1:0] DOOR_LAST = CW'(DOOR_TICKS - 1);

  localparam logic [1:0] DIR_NONE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DN   = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE   = 2'd1,
    SETTLE = 2'd2,
    OPEN   = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          stop_here;
  logic          at_end;

  assign stop_here = |(stop_req & position);

  // End floor in the latched travel direction; the car must not shift past it.
  always_comb begin
    at_end = 1'b0;
    if (dir == DIR_UP && position[3]) at_end = 1'b1;
    if (dir == DIR_DN && position[0]) at_end = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      position  <= 4'b0001;
      door_open <= 1'b0;
      moving    <= 1'b0;
      dir       <= DIR_NONE;
      arrive    <= 1'b0;
    end else begin
      arrive <= 1'b0;
      case (state)
        IDLE: begin
          if (stop_here || door_open_btn) begin
            state     <= OPEN;
            cnt       <= '0;
            door_open <= 1'b1;
            dir       <= DIR_NONE;
          end else if (ud_mode == DIR_UP && !position[3]) begin
            state  <= MOVE;
            cnt    <= '0;
            moving <= 1'b1;
            dir    <= DIR_UP;
          end else if (ud_mode == DIR_DN && !position[0]) begin
            state  <= MOVE;
            cnt    <= '0;
            moving <= 1'b1;
            dir    <= DIR_DN;
          end
        end

        MOVE: begin
          if (cnt == MOVE_LAST) begin
            state  <= SETTLE;
            cnt    <= '0;
            arrive <= 1'b1;
            if (dir == DIR_UP) position <= {position[2:0], 1'b0};
            else               position <= {1'b0, position[3:1]};
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        // ud_mode of 11 never equals a latched direction, so it opens like 00.
        SETTLE: begin
          cnt <= '0;
          if (stop_here || ud_mode != dir || at_end) begin
            state     <= OPEN;
            door_open <= 1'b1;
            moving    <= 1'b0;
            dir       <= DIR_NONE;
          end else begin
            state <= MOVE;
          end
        end

        OPEN: begin
          if (door_open_btn) begin
            cnt <= '0;
          end else if (door_close_btn || cnt == DOOR_LAST) begin
            state     <= IDLE;
            cnt       <= '0;
            door_open <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_car_motion_ctrl.sv
// Bench for car_motion_ctrl: directed vector table, hand-written corner cases,
// and randomized traffic compared every cycle against a floor/countdown model.
module tb_car_motion_ctrl;

  localparam int MOVE = 64;
  localparam int DOOR = 96;

  logic       clk;
  logic       rst_n;
  logic [1:0] ud_mode;
  logic [3:0] stop_req;
  logic       door_open_btn;
  logic       door_close_btn;
  logic [3:0] position;
  logic       door_open;
  logic       moving;
  logic [1:0] dir;
  logic       arrive;

  int n_checks = 0;
  int n_errors = 0;

  car_motion_ctrl #(.MOVE_TICKS(MOVE), .DOOR_TICKS(DOOR)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ud_mode        (ud_mode),
    .stop_req       (stop_req),
    .door_open_btn  (door_open_btn),
    .door_close_btn (door_close_btn),
    .position       (position),
    .door_open      (door_open),
    .moving         (moving),
    .dir            (dir),
    .arrive         (arrive)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: floor number plus countdowns of remaining travel / dwell.
  int m_floor  = 0;
  int m_travel = 0;
  int m_door   = 0;
  int m_dir    = 0;
  bit m_settle = 0;
  bit m_arr    = 0;

  function automatic logic [1:0] dcode(int d);
    if (d > 0) return 2'b01;
    if (d < 0) return 2'b10;
    return 2'b00;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_floor = 0; m_travel = 0; m_door = 0; m_dir = 0; m_settle = 0; m_arr = 0;
    end else begin
      m_arr = 0;
      if (m_travel > 0) begin
        m_travel = m_travel - 1;
        if (m_travel == 0) begin
          m_floor  = m_floor + m_dir;
          m_arr    = 1;
          m_settle = 1;
        end
      end else if (m_settle) begin
        m_settle = 0;
        if (stop_req[m_floor] || ud_mode != dcode(m_dir) ||
            (m_dir > 0 && m_floor == 3) || (m_dir < 0 && m_floor == 0)) begin
          m_door = DOOR;
          m_dir  = 0;
        end else begin
          m_travel = MOVE;
        end
      end else if (m_door > 0) begin
        if (door_open_btn)       m_door = DOOR;
        else if (door_close_btn) m_door = 0;
        else                     m_door = m_door - 1;
      end else if (stop_req[m_floor] || door_open_btn) begin
        m_door = DOOR;
      end else if (ud_mode == 2'b01 && m_floor < 3) begin
        m_dir = 1; m_travel = MOVE;
      end else if (ud_mode == 2'b10 && m_floor > 0) begin
        m_dir = -1; m_travel = MOVE;
      end
    end
  end

  function automatic logic [8:0] model_vec();
    logic [3:0] p;
    p = 4'b0001 << m_floor;
    return {p, (m_door > 0), (m_travel > 0 || m_settle), dcode(m_dir), m_arr};
  endfunction

  function automatic logic [8:0] dut_vec();
    return {position, door_open, moving, dir, arrive};
  endfunction

  // Scoreboard
  task automatic check_model();
    n_checks++;
    if (dut_vec() !== model_vec()) begin
      n_errors++;
      $display("FAIL model_cmp t=%0t got pos/door/mov/dir/arr=%b required %b",
               $time, dut_vec(), model_vec());
    end
  endtask

  task automatic check_exp(string name, logic [8:0] exp);
    n_checks++;
    if (dut_vec() !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t got pos/door/mov/dir/arr=%b required %b",
               name, $time, dut_vec(), exp);
    end
  endtask

  // Driver: inputs change on the falling edge, outputs are checked there too.
  task automatic tick();
    @(negedge clk);
    check_model();
  endtask

  task automatic drive(logic r, logic [1:0] ud, logic [3:0] st, logic ob, logic cb);
    rst_n = r; ud_mode = ud; stop_req = st; door_open_btn = ob; door_close_btn = cb;
  endtask

  typedef struct {
    logic [1:0] ud;
    logic [3:0] st;
    logic       ob;
    logic       cb;
    int         n;
    logic [3:0] pos;
    logic       door;
    logic       mov;
    logic [1:0] d;
    logic       arr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [1:0] ud, logic [3:0] st, logic ob, logic cb, int n,
                              logic [3:0] pos, logic door, logic mov, logic [1:0] d,
                              logic arr);
    vec_t v;
    v.ud = ud; v.st = st; v.ob = ob; v.cb = cb; v.n = n;
    v.pos = pos; v.door = door; v.mov = mov; v.d = d; v.arr = arr;
    return v;
  endfunction

  initial begin
    // two-floor trip 1 -> 3
    tbl.push_back(mk(2'b01, 4'b0100, 0, 0,  1, 4'b0001, 0, 1, 2'b01, 0));
    tbl.push_back(mk(2'b01, 4'b0100, 0, 0, 63, 4'b0001, 0, 1, 2'b01, 0));
    tbl.push_back(mk(2'b01, 4'b0100, 0, 0,  1, 4'b0010, 0, 1, 2'b01, 1));
    tbl.push_back(mk(2'b01, 4'b0100, 0, 0,  1, 4'b0010, 0, 1, 2'b01, 0));
    tbl.push_back(mk(2'b01, 4'b0100, 0, 0, 64, 4'b0100, 0, 1, 2'b01, 1));
    tbl.push_back(mk(2'b01, 4'b0100, 0, 0,  1, 4'b0100, 1, 0, 2'b00, 0));
    tbl.push_back(mk(2'b00, 4'b0000, 0, 0, 95, 4'b0100, 1, 0, 2'b00, 0));
    tbl.push_back(mk(2'b00, 4'b0000, 0, 0,  1, 4'b0100, 0, 0, 2'b00, 0));
    // up to top floor, then up request at top is ignored
    tbl.push_back(mk(2'b01, 4'b1000, 0, 0,  1, 4'b0100, 0, 1, 2'b01, 0));
    tbl.push_back(mk(2'b01, 4'b1000, 0, 0, 64, 4'b1000, 0, 1, 2'b01, 1));
    tbl.push_back(mk(2'b01, 4'b1000, 0, 0,  1, 4'b1000, 1, 0, 2'b00, 0));
    tbl.push_back(mk(2'b00, 4'b0000, 0, 1,  1, 4'b1000, 0, 0, 2'b00, 0));
    tbl.push_back(mk(2'b01, 4'b0000, 0, 0, 20, 4'b1000, 0, 0, 2'b00, 0));
    // three floors down, then down request at bottom is ignored
    tbl.push_back(mk(2'b10, 4'b0001, 0, 0,   1, 4'b1000, 0, 1, 2'b10, 0));
    tbl.push_back(mk(2'b10, 4'b0001, 0, 0, 194, 4'b0001, 0, 1, 2'b10, 1));
    tbl.push_back(mk(2'b10, 4'b0001, 0, 0,   1, 4'b0001, 1, 0, 2'b00, 0));
    tbl.push_back(mk(2'b00, 4'b0000, 0, 1,   1, 4'b0001, 0, 0, 2'b00, 0));
    tbl.push_back(mk(2'b10, 4'b0000, 0, 0,  20, 4'b0001, 0, 0, 2'b00, 0));
    // reversal in flight: car completes the floor, then opens
    tbl.push_back(mk(2'b01, 4'b0000, 0, 0,  1, 4'b0001, 0, 1, 2'b01, 0));
    tbl.push_back(mk(2'b10, 4'b0000, 0, 0, 30, 4'b0001, 0, 1, 2'b01, 0));
    tbl.push_back(mk(2'b10, 4'b0000, 0, 0, 34, 4'b0010, 0, 1, 2'b01, 1));
    tbl.push_back(mk(2'b10, 4'b0000, 0, 0,  1, 4'b0010, 1, 0, 2'b00, 0));
    // open button at dwell count 90 restarts a full dwell
    tbl.push_back(mk(2'b10, 4'b0000, 0, 0, 90, 4'b0010, 1, 0, 2'b00, 0));
    tbl.push_back(mk(2'b00, 4'b0000, 1, 0,  1, 4'b0010, 1, 0, 2'b00, 0));
    tbl.push_back(mk(2'b00, 4'b0000, 0, 0, 95, 4'b0010, 1, 0, 2'b00, 0));
    tbl.push_back(mk(2'b00, 4'b0000, 0, 0,  1, 4'b0010, 0, 0, 2'b00, 0));
    // open from IDLE by button, close at dwell count 10
    tbl.push_back(mk(2'b00, 4'b0000, 1, 0,  1, 4'b0010, 1, 0, 2'b00, 0));
    tbl.push_back(mk(2'b00, 4'b0000, 0, 0, 10, 4'b0010, 1, 0, 2'b00, 0));
    tbl.push_back(mk(2'b00, 4'b0000, 0, 1,  1, 4'b0010, 0, 0, 2'b00, 0));

    // reset with random inputs for two cycles
    drive(0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    tick();
    drive(0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    tick();
    check_exp("reset", 9'b0001_0_0_00_0);

    foreach (tbl[i]) begin
      drive(1, tbl[i].ud, tbl[i].st, tbl[i].ob, tbl[i].cb);
      repeat (tbl[i].n) tick();
      check_exp($sformatf("vec%0d", i),
                {tbl[i].pos, tbl[i].door, tbl[i].mov, tbl[i].d, tbl[i].arr});
    end

    // reset mid-move between floors 2 and 3
    drive(1, 2'b01, 4'b0000, 0, 0);
    tick();
    check_exp("mid_move_start", 9'b0010_0_1_01_0);
    repeat (30) tick();
    check_exp("mid_move_cnt30", 9'b0010_0_1_01_0);
    drive(0, 2'b01, 4'b0000, 0, 0);
    tick();
    check_exp("mid_move_reset", 9'b0001_0_0_00_0);
    drive(1, 2'b00, 4'b0000, 0, 0);
    repeat (3) tick();
    check_exp("post_reset_idle", 9'b0001_0_0_00_0);

    // both buttons held: open wins, door stays open past a full dwell
    drive(1, 2'b00, 4'b0000, 1, 1);
    tick();
    check_exp("both_btn_open", 9'b0001_1_0_00_0);
    repeat (120) tick();
    check_exp("both_btn_held", 9'b0001_1_0_00_0);
    drive(1, 2'b00, 4'b0000, 0, 1);
    tick();
    check_exp("close_after_both", 9'b0001_0_0_00_0);

    // randomized traffic against the model
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 49) == 0) ud_mode  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0) stop_req = 4'($urandom_range(0, 15));
      door_open_btn  = ($urandom_range(0, 79) == 0);
      door_close_btn = ($urandom_range(0, 49) == 0);
      rst_n          = ($urandom_range(0, 999) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
